// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch front end.
// Owns the PC, drives iaddr to imem, captures {pc, idata} into a small fetch
// queue and presents the queue head to decode with a valid/ready handshake.
// Redirects from execute flush the queue and reload the PC.
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   defined   -> misaligned redirect targets raise a sticky fetch_fault and
//                stop fetching until an aligned redirect arrives.
//   undefined -> redirect_pc[1:0] is dropped; fetch_fault is tied low.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Queue storage; contents are only meaningful under count_q, so no reset.
  logic [31:0]   ent_pc_q   [FQ_DEPTH];
  logic [31:0]   ent_inst_q [FQ_DEPTH];

  logic          pop;
  logic          push;
  logic          halted;
  logic [31:0]   redirect_tgt;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  // Every redirect re-evaluates the fault: misaligned sets it, aligned clears it.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) begin
      fault_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  // Sticky fault register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign redirect_tgt = redirect_pc;
  assign halted       = fault_q;
  assign fetch_fault  = fault_q;
`else
  // Low target bits are intentionally discarded in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign halted       = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  // Handshake: a redirect kills both the pop and the push of its cycle.
  assign if_valid = (count_q != '0);
  assign pop      = if_valid & id_ready & ~redirect_valid;
  assign push     = ~redirect_valid & ~halted & ((count_q < DEPTH_C) | pop);

  assign iaddr    = pc_q;
  assign if_pc    = if_valid ? ent_pc_q[rd_ptr_q]   : 32'h0;
  assign if_inst  = if_valid ? ent_inst_q[rd_ptr_q] : 32'h0;

  // Next-state for PC, pointers and occupancy; redirect overrides everything.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_tgt;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Capture the fetched word and its PC at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[wr_ptr_q]   <= pc_q;
      ent_inst_q[wr_ptr_q] <= idata;
    end
  end

endmodule
